// File: rtl/con_pkg.sv
// Shared constants for the CON flip-flop: C2 branch encodings and default geometry.
package con_pkg;

    localparam int unsigned CON_WIDTH  = 32;
    localparam int unsigned CON_C2_LSB = 19;

    localparam logic [1:0] C2_BRZR = 2'b00;
    localparam logic [1:0] C2_BRNZ = 2'b01;
    localparam logic [1:0] C2_BRPL = 2'b10;
    localparam logic [1:0] C2_BRMI = 2'b11;

endpackage

// File: rtl/con_dec_2to4.sv
// 2-to-4 one-hot decoder for the C2 branch-condition field.
module con_dec_2to4
    import con_pkg::*;
(
    input  logic [1:0] i_sel,
    output logic [3:0] o_dec
);

    always_comb begin
        o_dec = 4'b0000;
        case (i_sel)
            C2_BRZR: o_dec = 4'b0001;
            C2_BRNZ: o_dec = 4'b0010;
            C2_BRPL: o_dec = 4'b0100;
            C2_BRMI: o_dec = 4'b1000;
            default: o_dec = 4'b0000;
        endcase
    end

endmodule

// File: rtl/con_ff_unit.sv
// Branch-condition flip-flop: tests the bus against the IR C2 field and registers the decision.
// Optional macro CON_DEBUG_EN exposes the live decoder output and unregistered condition.
module con_ff_unit
    import con_pkg::*;
#(
    parameter int unsigned WIDTH  = CON_WIDTH,
    parameter int unsigned C2_LSB = CON_C2_LSB
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             CONin,
    input  logic [WIDTH-1:0] ir,
    input  logic [WIDTH-1:0] bus,
    output logic             con_out
`ifdef CON_DEBUG_EN
    ,
    output logic [3:0]       con_dec,
    output logic [0:0]       con_raw
`endif
);

    logic [1:0] w_c2;
    logic [3:0] w_dec;
    logic       w_zero;
    logic       w_neg;
    logic       w_cond;
    logic       w_unused_ir;
    logic       r_con = 1'b0;

    assign w_c2        = ir[C2_LSB+1:C2_LSB];
    assign w_unused_ir = ^{ir[WIDTH-1:C2_LSB+2], ir[C2_LSB-1:0]};

    con_dec_2to4 u_dec (
        .i_sel (w_c2),
        .o_dec (w_dec)
    );

    assign w_zero = (bus == '0);
    assign w_neg  = bus[WIDTH-1];

    // One-hot AND-OR select; zero counts as positive for brpl.
    assign w_cond = |(w_dec & {w_neg, ~w_neg, ~w_zero, w_zero});

    always_ff @(posedge clk) begin
        if (clr) begin
            r_con <= 1'b0;
        end else if (CONin) begin
            r_con <= w_cond;
        end
    end

    assign con_out = r_con;

`ifdef CON_DEBUG_EN
    assign con_dec = w_dec;
    assign con_raw = w_cond;
`endif

`ifndef SYNTHESIS
    // An unknown C2 while loading would make the branch decision meaningless.
    property p_c2_known;
        @(posedge clk) disable iff (clr) CONin |-> !$isunknown(w_c2);
    endproperty
    a_c2_known: assert property (p_c2_known)
        else $error("con_ff_unit: X/Z on C2 field while CONin asserted");
`endif

endmodule

// File: tb/tb_con_ff_unit.sv
// Directed self-checking bench for con_ff_unit.
module tb_con_ff_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         CONin = 1'b0;
    logic [W-1:0] ir = '0;
    logic [W-1:0] bus = '0;
    logic         con_out;
`ifdef CON_DEBUG_EN
    logic [3:0]   con_dec;
    logic [0:0]   con_raw;
`endif

    int tests = 0;
    int fails = 0;

    con_ff_unit #(.WIDTH(32), .C2_LSB(19)) dut (
        .clk     (clk),
        .clr     (clr),
        .CONin   (CONin),
        .ir      (ir),
        .bus     (bus),
        .con_out (con_out)
`ifdef CON_DEBUG_EN
        ,
        .con_dec (con_dec),
        .con_raw (con_raw)
`endif
    );

    always #5 clk = ~clk;

    // Random IR with the C2 field forced; other bits must be ignored.
    function automatic logic [W-1:0] mk_ir(input logic [1:0] c2);
        logic [W-1:0] v;
        v = W'($urandom);
        v[20:19] = c2;
        return v;
    endfunction

    task automatic chk(input string tag, input logic exp);
        tests++;
        assert (con_out === exp)
        else begin
            fails++;
            $error("FAIL %s: con_out=%b expected=%b", tag, con_out, exp);
        end
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic c, input logic ld, input logic [1:0] c2, input logic [W-1:0] b);
        clr   = c;
        CONin = ld;
        ir    = mk_ir(c2);
        bus   = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("powerup", 1'b0);

        step(1'b1, 1'b0, 2'b00, 32'h0);
        chk("reset", 1'b0);
        step(1'b0, 1'b0, 2'b00, 32'h0);
        chk("reset_release", 1'b0);

        step(1'b0, 1'b1, 2'b00, 32'h0000_0000);
        chk("brzr_zero", 1'b1);
        step(1'b0, 1'b1, 2'b00, 32'h0000_0001);
        chk("brzr_nonzero", 1'b0);

        step(1'b0, 1'b1, 2'b01, 32'h0000_0005);
        chk("brnz_nonzero", 1'b1);
        step(1'b0, 1'b1, 2'b01, 32'h0000_0000);
        chk("brnz_zero", 1'b0);

        step(1'b0, 1'b1, 2'b10, 32'h8000_0000);
        chk("brpl_neg", 1'b0);
        step(1'b0, 1'b1, 2'b11, 32'h8000_0000);
        chk("brmi_neg", 1'b1);
        step(1'b0, 1'b1, 2'b10, 32'h7FFF_FFFF);
        chk("brpl_pos", 1'b1);
        step(1'b0, 1'b1, 2'b11, 32'h7FFF_FFFF);
        chk("brmi_pos", 1'b0);
        step(1'b0, 1'b1, 2'b10, 32'h0000_0000);
        chk("brpl_zero", 1'b1);
        step(1'b0, 1'b1, 2'b11, 32'h0000_0000);
        chk("brmi_zero", 1'b0);

        // Load a 1, then sweep inputs with CONin low: value must hold.
        step(1'b0, 1'b1, 2'b00, 32'h0);
        chk("hold_setup", 1'b1);
        step(1'b0, 1'b0, 2'b00, 32'h0000_0001);
        chk("hold_0", 1'b1);
        step(1'b0, 1'b0, 2'b01, 32'h0000_0000);
        chk("hold_1", 1'b1);
        step(1'b0, 1'b0, 2'b10, 32'h8000_0000);
        chk("hold_2", 1'b1);
        step(1'b0, 1'b0, 2'b11, 32'h7FFF_FFFF);
        chk("hold_3", 1'b1);
        step(1'b0, 1'b0, 2'b00, 32'hDEAD_BEEF);
        chk("hold_4", 1'b1);

        // No combinational path: change inputs between edges.
        CONin = 1'b1;
        ir    = mk_ir(2'b00);
        bus   = 32'h1234_5678;
        #2;
        chk("no_comb_path", 1'b1);
        @(posedge clk);
        #1;
        chk("load_after_edge", 1'b0);

        // CONin held high reloads every cycle.
        step(1'b0, 1'b1, 2'b11, 32'hFFFF_FFFF);
        chk("cont_load_0", 1'b1);
        step(1'b0, 1'b1, 2'b01, 32'h0);
        chk("cont_load_1", 1'b0);
        step(1'b0, 1'b1, 2'b01, 32'h0000_0100);
        chk("cont_load_2", 1'b1);

        // Reset wins over a simultaneous load whose cond is 1.
        step(1'b1, 1'b1, 2'b00, 32'h0);
        chk("priority_clr", 1'b0);
        step(1'b0, 1'b0, 2'b00, 32'h0);
        chk("after_priority", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
